// File: rtl/alu_serial_port.sv
// ---------------------------------------------------------------------------
// alu_serial_port
//
// Purpose:
//   Sits in front of the bit-serial ALU on its external-argument path.
//   Operand bytes arrive from the memory/prefetch side and are packed into a
//   2*REG_BITS shift register.  While the ALU is active, that register shifts
//   right by NSHIFT bits per cycle: the low bits feed the ALU data input and
//   the ALU result bits enter at the top.  After the ALU signals completion,
//   the collected result is handed back as bytes for memory writeback.
//
// Parameters:
//   REG_BITS - bits per register/byte (a pair is 2*REG_BITS)
//   NSHIFT   - bits moved per ALU cycle (must divide REG_BITS)
//
// Ports:
//   clk           in   clock
//   reset_n       in   asynchronous reset, active low
//   cmd_valid     in   transfer command offered
//   cmd_ready     out  command accepted when cmd_valid && cmd_ready
//   cmd_pair      in   1 = 2*REG_BITS operand/result, 0 = REG_BITS
//   cmd_load      in   1 = fetch operand bytes first, 0 = reuse shift register
//   cmd_store     in   1 = emit result bytes after the run
//   rx_valid      in   operand byte offered
//   rx_ready      out  operand byte accepted when rx_valid && rx_ready
//   rx_data       in   operand byte, low byte first
//   alu_active    in   ALU shift enable for this cycle
//   alu_done      in   ALU op_done
//   alu_data_in   out  serial operand bits to the ALU
//   alu_data_out  in   serial result bits from the ALU
//   tx_valid      out  result byte offered
//   tx_ready      in   result byte consumed when tx_valid && tx_ready
//   tx_data       out  result byte, low byte first
//   busy          out  block is not idle
// ---------------------------------------------------------------------------
module alu_serial_port #(
    parameter int REG_BITS = 8,
    parameter int NSHIFT   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_pair,
    input  logic                cmd_load,
    input  logic                cmd_store,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic [REG_BITS-1:0] rx_data,
    input  logic                alu_active,
    input  logic                alu_done,
    output logic [NSHIFT-1:0]   alu_data_in,
    input  logic [NSHIFT-1:0]   alu_data_out,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [REG_BITS-1:0] tx_data,
    output logic                busy
);

    localparam int PAIR_BITS = 2 * REG_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PAIR_BITS-1:0] sreg_q,  sreg_d;
    logic                 bcnt_q,  bcnt_d;
    logic                 pair_q,  pair_d;
    logic                 load_q,  load_d;
    logic                 store_q, store_d;

    logic                 cmdReadyInt;

    // State and datapath registers; everything returns to an empty, idle
    // port the moment reset_n drops, even in the middle of a run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            bcnt_q  <= 1'b0;
            pair_q  <= 1'b0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            bcnt_q  <= bcnt_d;
            pair_q  <= pair_d;
            load_q  <= load_d;
            store_q <= store_d;
        end
    end

    // Next-state and output logic.  Every output depends only on registered
    // state, so there is no combinational path from the handshake inputs to
    // any output.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        bcnt_d      = bcnt_q;
        pair_d      = pair_q;
        load_d      = load_q;
        store_d     = store_q;
        cmdReadyInt = 1'b0;
        rx_ready    = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = '0;
        alu_data_in = '0;

        case (state_q)
            IDLE: begin
                cmdReadyInt = 1'b1;
                if (cmd_valid) begin
                    pair_d  = cmd_pair;
                    load_d  = cmd_load;
                    store_d = cmd_store;
                    bcnt_d  = 1'b0;
                    // Without a load the shift register is left untouched so
                    // the previous result becomes the next operand.
                    state_d = cmd_load ? FETCH : RUN;
                end
            end

            FETCH: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (!bcnt_q) begin
                        sreg_d[REG_BITS-1:0] = rx_data;
                        // A single-byte operand must not inherit stale upper
                        // bits, since they shift into the ALU after the
                        // operand and appear in the low result byte.
                        if (!pair_q) begin
                            sreg_d[PAIR_BITS-1:REG_BITS] = '0;
                        end
                    end else begin
                        sreg_d[PAIR_BITS-1:REG_BITS] = rx_data;
                    end
                    bcnt_d = bcnt_q + 1'b1;
                    if (!pair_q || bcnt_q) begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                alu_data_in = sreg_q[NSHIFT-1:0];
                // Shift count is not tracked here: the ALU's done flag alone
                // ends the run, which lets timed rotates stop early.  A done
                // flag without a shift enable is ignored.
                if (alu_active) begin
                    sreg_d = {alu_data_out, sreg_q[PAIR_BITS-1:NSHIFT]};
                    if (alu_done) begin
                        bcnt_d  = 1'b0;
                        state_d = store_q ? WRITE : IDLE;
                    end
                end
            end

            WRITE: begin
                tx_valid = 1'b1;
                // A single-byte result has been shifted all the way into the
                // upper half; a pair leaves low byte then high byte.
                if (pair_q && !bcnt_q) begin
                    tx_data = sreg_q[REG_BITS-1:0];
                end else begin
                    tx_data = sreg_q[PAIR_BITS-1:REG_BITS];
                end
                if (tx_ready) begin
                    if (!pair_q || bcnt_q) begin
                        bcnt_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        bcnt_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The idle state is also the reset state, so the command handshake is
    // additionally gated by reset_n to keep it low while reset is held.
    assign cmd_ready = cmdReadyInt & reset_n;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/alu_serial_port.md
Name: alu_serial_port

Overview:
- Byte-to-serial operand feeder and serial-to-byte result collector in front of the serial ALU.
- Accepts operand bytes from the memory/prefetch side, then shifts them out NSHIFT bits per cycle on the ALU's external data input while capturing the ALU's data output.
- Returns the collected result as bytes for memory writeback.
- One instance serves the ALU's external-argument path: data_in1/data_in2 and data_out.

Parameters:
- REG_BITS, 8, bits per register/byte; a pair is 2*REG_BITS.
- NSHIFT, 2, bits moved per ALU cycle; must divide REG_BITS.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  new transfer command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_pair  in  1  1 = 16-bit operand/result, 0 = 8-bit.
- cmd_load  in  1  1 = fetch operand bytes before running; 0 = reuse current shift register.
- cmd_store  in  1  1 = emit result bytes after running.
- rx_valid  in  1  operand byte offered.
- rx_ready  out  1  operand byte accepted when rx_valid && rx_ready.
- rx_data  in  REG_BITS  operand byte, low byte first.
- alu_active  in  1  ALU active (shift enable) for this cycle.
- alu_done  in  1  ALU op_done.
- alu_data_in  out  NSHIFT  to ALU data_in1/data_in2.
- alu_data_out  in  NSHIFT  from ALU data_out.
- tx_valid  out  1  result byte offered.
- tx_ready  in  1  result byte consumed when tx_valid && tx_ready.
- tx_data  out  REG_BITS  result byte, low byte first.
- busy  out  1  state != IDLE.

Behaviour:
- State: sreg[2*REG_BITS-1:0], byte counter bcnt (1 bit), latched pair/load/store, FSM IDLE/FETCH/RUN/WRITE.
- Reset (reset_n low, asynchronous, any state, mid-operation included):
  - state=IDLE; sreg=0; bcnt=0.
  - All outputs low: cmd_ready becomes 1 only when reset_n is high.
- IDLE:
  - cmd_ready=1.
  - On accept, latch cmd_pair/cmd_load/cmd_store and clear bcnt.
  - Next state is FETCH if cmd_load, else RUN. With cmd_load=0, sreg is kept, so the previous result is the operand.
- FETCH:
  - rx_ready=1.
  - Byte 0 writes sreg[7:0]. For an 8-bit command, sreg[15:8] is cleared in the same cycle.
  - Byte 1 (pair only) writes sreg[15:8].
  - Go to RUN in the cycle after the last byte is accepted; bcnt increments per byte.
- RUN:
  - alu_data_in = sreg[NSHIFT-1:0] combinationally; 0 in all other states.
  - When alu_active: sreg <= {alu_data_out, sreg[2*REG_BITS-1:NSHIFT]}. The operand LSBs leave first and result bits enter at the top.
  - alu_active && alu_done: final shift still occurs. Next state is WRITE if store, else IDLE.
  - alu_done without alu_active is ignored.
  - Nominal run length is REG_BITS/NSHIFT shifts (8-bit) or 2*REG_BITS/NSHIFT shifts (pair). The block does not count shifts; it obeys alu_done only (timed rotates may be shorter).
- WRITE:
  - tx_valid=1.
  - 8-bit command: tx_data=sreg[15:8], the result after 4 shifts.
  - Pair command: tx_data=sreg[7:0] then sreg[15:8].
  - tx_data is held stable while tx_valid && !tx_ready.
  - After the last byte is accepted, go to IDLE.
- Output qualification: cmd_ready, rx_ready and tx_valid are never asserted outside their own state.
- No combinational path from cmd_valid, rx_valid or tx_ready to any output.
- Throughput: back-to-back bytes at 1 per cycle in FETCH and WRITE. At least 1 IDLE cycle between commands.

Test Plan:
1. Reset mid-RUN: assert reset_n=0 asynchronously → same-cycle busy=0, alu_data_in=0, tx_valid=0; after release, cmd_ready=1 and sreg=0.
2. 8-bit load/store passthrough: rx 0xB4; ALU models MOV (data_out=data_in) for 4 active cycles with alu_done on the 4th.
   - alu_data_in sequence 0,1,3,2 (2-bit values).
   - tx_data=0xB4, single byte, then IDLE.
3. Pair load/store: rx 0x34 then 0x12; ALU echoes data_in inverted for 8 cycles → tx 0xCB then 0xED.
4. Stalls:
   - alu_active low for 3 cycles mid-RUN → sreg and alu_data_in unchanged.
   - tx_ready low for 5 cycles → tx_data held at 0xCB.
5. Chaining: cmd_load=0, cmd_store=1 after test 3 → operand is 0xEDCB; echo ALU returns tx 0xCB, 0xED.
6. Early done: pair command with alu_done on the 2nd active cycle (timed rotate) → exactly 2 shifts, then WRITE. alu_done while alu_active=0 does not leave RUN.
